// File: rtl/mux_2in_32data.sv
// Two-input datapath multiplexer with an optional registered observation stage.
// Define MUX_2IN_32DATA_OBS_EN to build out_q/select_q/changed/switch_count; otherwise they read 0.
module mux_2in_32data #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 select,
   input  logic [WIDTH-1:0]     in_0,
   input  logic [WIDTH-1:0]     in_1,
   output logic [WIDTH-1:0]     out,
   output logic [WIDTH-1:0]     out_q,
   output logic                 select_q,
   output logic                 changed,
   output logic [CNT_WIDTH-1:0] switch_count
);

   // The datapath result never touches clk or rst.
   assign out = select ? in_1 : in_0;

`ifdef MUX_2IN_32DATA_OBS_EN
   logic [WIDTH-1:0]     r_out_q;
   logic                 r_select_q;
   logic                 r_changed;
   logic [CNT_WIDTH-1:0] r_switch_count;
   logic                 w_changed;
   logic                 w_saturated;

   assign w_changed   = (select != r_select_q);
   assign w_saturated = (r_switch_count == {CNT_WIDTH{1'b1}});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_q        <= '0;
         r_select_q     <= 1'b0;
         r_changed      <= 1'b0;
         r_switch_count <= '0;
      end else begin
         r_out_q    <= out;
         r_select_q <= select;
         r_changed  <= w_changed;
         // Saturate instead of wrapping so a long-running count stays meaningful.
         if (w_changed && !w_saturated) begin
            r_switch_count <= r_switch_count + 1'b1;
         end
      end
   end

   assign out_q        = r_out_q;
   assign select_q     = r_select_q;
   assign changed      = r_changed;
   assign switch_count = r_switch_count;
`else
   logic w_unused;
   assign w_unused     = ^{clk, rst};
   assign out_q        = '0;
   assign select_q     = 1'b0;
   assign changed      = 1'b0;
   assign switch_count = '0;
`endif

endmodule

// File: tb/tb_mux_2in_32data.sv
// Randomized scoreboard bench for mux_2in_32data; follows MUX_2IN_32DATA_OBS_EN like the design.
module tb_mux_2in_32data;
   localparam int W  = 32;
   localparam int CW = 16;
   localparam int EW = W + 1 + 1 + CW;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic          clk;
   logic          clk_en;
   logic          rst;
   logic          select;
   logic [W-1:0]  in_0;
   logic [W-1:0]  in_1;
   logic [W-1:0]  out;
   logic [W-1:0]  out_q;
   logic          select_q;
   logic          changed;
   logic [CW-1:0] switch_count;

   logic [EW-1:0] exp_q[$];
   int n_vectors;
   int n_miscompares;

   // Reference state: what the observation registers should hold after each edge.
   logic [W-1:0]  m_out_q;
   logic          m_sel_q;
   logic          m_chg;
   int            m_cnt;

   mux_2in_32data #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .select(select), .in_0(in_0), .in_1(in_1),
      .out(out), .out_q(out_q), .select_q(select_q), .changed(changed),
      .switch_count(switch_count)
   );

   // Clock / reset block: clock is held low until enabled.
   initial begin
      clk    = 1'b0;
      clk_en = 1'b0;
   end
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Driver: apply one cycle of stimulus away from the rising edge and record the expectation.
   task automatic step(input logic r, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] exp_out;
      @(negedge clk);
      rst = r; select = s; in_0 = a; in_1 = b;
      exp_out = (s == 1'b1) ? b : a;
      #1;
      chk("out_comb", 64'(out), 64'(exp_out));
`ifdef MUX_2IN_32DATA_OBS_EN
      if (r) begin
         m_out_q = '0; m_sel_q = 1'b0; m_chg = 1'b0; m_cnt = 0;
      end else begin
         m_chg = (s != m_sel_q);
         if (m_chg) m_cnt = (m_cnt + 1 > int'(CNT_MAX)) ? int'(CNT_MAX) : m_cnt + 1;
         m_sel_q = s;
         m_out_q = exp_out;
      end
`else
      m_out_q = '0; m_sel_q = 1'b0; m_chg = 1'b0; m_cnt = 0;
`endif
      exp_q.push_back({m_out_q, m_sel_q, m_chg, CW'(m_cnt)});
   endtask

   // Monitor: every rising edge retires one expectation.
   always @(posedge clk) begin
      logic [EW-1:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("out_q",        64'(out_q),        64'(e[EW-1 -: W]));
         chk("select_q",     64'(select_q),     64'(e[CW+1]));
         chk("changed",      64'(changed),      64'(e[CW]));
         chk("switch_count", 64'(switch_count), 64'(e[CW-1:0]));
      end
   end

   initial begin
      logic s;
      int   guard;
      n_vectors = 0; n_miscompares = 0;
      m_out_q = '0; m_sel_q = 1'b0; m_chg = 1'b0; m_cnt = 0;

      // Purely combinational path with no clock and no reset.
      rst = 1'b0; in_0 = 32'hAA; in_1 = 32'hBB; select = 1'b0;
      #10;
      chk("noclk_sel0", 64'(out), 64'h0000_00AA);
      select = 1'b1;
      #10;
      chk("noclk_sel1", 64'(out), 64'h0000_00BB);
`ifndef MUX_2IN_32DATA_OBS_EN
      chk("noclk_out_q", 64'(out_q), 64'h0);
      chk("noclk_count", 64'(switch_count), 64'h0);
`endif
      clk_en = 1'b1;

      // Two reset cycles with random data, then release.
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      step(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);

      // in_0 changes under select=0: out follows at once, out_q on the next edge.
      step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
      step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);

      // Five toggles from 1 after reset, then hold for three cycles.
      step(1'b1, 1'b0, $urandom, $urandom);
      for (int i = 0; i < 5; i++) step(1'b0, 1'((i + 1) % 2), $urandom, $urandom);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, $urandom);
      @(posedge clk); #2;
`ifdef MUX_2IN_32DATA_OBS_EN
      chk("count_after_5", 64'(switch_count), 64'd5);
`else
      chk("count_tied", 64'(switch_count), 64'd0);
`endif

      // Random traffic with occasional mid-run resets.
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom);

`ifdef MUX_2IN_32DATA_OBS_EN
      // Saturation: 65,540 transitions after reset.
      step(1'b1, 1'b0, $urandom, $urandom);
      s = 1'b0;
      for (int i = 0; i < 65540; i++) begin
         s = ~s;
         step(1'b0, s, $urandom, $urandom);
      end
      @(posedge clk); #2;
      chk("count_saturated", 64'(switch_count), 64'(CNT_MAX));
      step(1'b1, ~s, $urandom, $urandom);
      @(posedge clk); #2;
      chk("count_after_rst", 64'(switch_count), 64'd0);
`endif

      // Drain the scoreboard with a bounded wait.
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk); #2;
         guard++;
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
